// File: rtl/led_sync_rx.sv
// Serial-in/parallel-out receiver for the LED shift-register link; rebuilds the HEXS word.
// Optional build macro LED_RX_CLR_EN makes a synchronized ser_clr=0 clear the receiver.
module led_sync_rx #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ser_clk,
  input  logic             ser_do,
  input  logic             ser_clr,
  output logic [WIDTH-1:0] hexs,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BC_W = $clog2(WIDTH + 1);
  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_next;
  logic [BC_W-1:0]  bit_cnt;
  logic [BC_W-1:0]  cnt_next;
  logic [TO_W-1:0]  to_cnt;

  logic sync1_clk, sync2_clk, sync3_clk;
  logic sync1_do, sync2_do;
  logic edge_q, bit_q;
  logic clr_req;

  // Synchronizers idle at the line's resting level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_clk <= 1'b1;
      sync2_clk <= 1'b1;
      sync3_clk <= 1'b1;
      sync1_do  <= 1'b1;
      sync2_do  <= 1'b1;
      edge_q    <= 1'b0;
      bit_q     <= 1'b0;
    end else begin
      sync1_clk <= ser_clk;
      sync2_clk <= sync1_clk;
      sync3_clk <= sync2_clk;
      sync1_do  <= ser_do;
      sync2_do  <= sync1_do;
      edge_q    <= sync2_clk & ~sync3_clk;
      bit_q     <= ~sync2_do;
    end
  end

`ifdef LED_RX_CLR_EN
  logic sync1_clr, sync2_clr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_clr <= 1'b1;
      sync2_clr <= 1'b1;
    end else begin
      sync1_clr <= ser_clr;
      sync2_clr <= sync1_clr;
    end
  end

  assign clr_req = ~sync2_clr;
`else
  logic unused_clr;

  assign unused_clr = ser_clr;
  assign clr_req    = 1'b0;
`endif

  assign shift_next = (shift << 1) | WIDTH'(bit_q);
  assign cnt_next   = ((state == SHIFT) ? bit_cnt : '0) + BC_W'(1);

  // Frame FSM: an edge always wins over timeout, and clear wins over an edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      hexs        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (clr_req) begin
        state   <= IDLE;
        busy    <= 1'b0;
        shift   <= '0;
        bit_cnt <= '0;
        to_cnt  <= '0;
        hexs    <= '0;
      end else if (edge_q) begin
        to_cnt <= '0;
        shift  <= shift_next;
        if (cnt_next == BC_W'(WIDTH)) begin
          hexs        <= shift_next;
          frame_valid <= 1'b1;
          frame_cnt   <= frame_cnt + CNT_W'(1);
          bit_cnt     <= '0;
          state       <= IDLE;
          busy        <= 1'b0;
        end else begin
          bit_cnt <= cnt_next;
          state   <= SHIFT;
          busy    <= 1'b1;
        end
      end else if (state == SHIFT) begin
        if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          busy      <= 1'b0;
          bit_cnt   <= '0;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_sync_rx.sv
// Randomized self-checking bench for led_sync_rx against a bit-queue reference model.
module tb_led_sync_rx;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 1024;
  localparam int CNT_W   = 8;
  localparam int PERIOD  = 10;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             ser_clk = 1'b0;
  logic             ser_do = 1'b1;
  logic             ser_clr = 1'b1;
  logic [WIDTH-1:0] hexs;
  logic             frame_valid;
  logic             frame_err;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  led_sync_rx #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .ser_clk(ser_clk), .ser_do(ser_do), .ser_clr(ser_clr),
    .hexs(hexs), .frame_valid(frame_valid), .frame_err(frame_err),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #(PERIOD/2) clk = ~clk;

  int passed = 0;
  int total  = 0;

  int valid_seen = 0;
  int err_seen   = 0;
  int both_seen  = 0;
  int since_rise = 0;
  int last_lat   = -1;
  logic [WIDTH-1:0] obs_frames[$];

  // Reference model: bits since the last frame boundary, plus expected results.
  int               model_bits[$];
  logic [WIDTH-1:0] exp_frames[$];
  logic [WIDTH-1:0] exp_hexs = '0;
  int               exp_cnt  = 0;

  always @(posedge clk) since_rise++;

  always @(negedge clk) begin
    if (frame_valid) begin
      valid_seen++;
      last_lat = since_rise;
      obs_frames.push_back(hexs);
    end
    if (frame_err) err_seen++;
    if (frame_valid && frame_err) both_seen++;
  end

  initial begin
    #(PERIOD * 60000);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_push(input int b);
    logic [WIDTH-1:0] w;
    model_bits.push_back(b);
    if (model_bits.size() == WIDTH) begin
      w = '0;
      for (int i = 0; i < WIDTH; i++)
        if (model_bits[i] != 0) w[WIDTH-1-i] = 1'b1;
      exp_frames.push_back(w);
      exp_hexs = w;
      exp_cnt  = (exp_cnt + 1) % (1 << CNT_W);
      model_bits.delete();
    end
  endtask

  task automatic model_reset();
    model_bits.delete();
    exp_hexs = '0;
    exp_cnt  = 0;
  endtask

  task automatic send_bit(input int b, input int half);
    ser_do = (b != 0) ? 1'b0 : 1'b1;
    tick(half);
    ser_clk    = 1'b1;
    since_rise = 0;
    tick(half);
    ser_clk = 1'b0;
    model_push(b);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int half);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i] ? 1 : 0, half);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(3);
    total++; if (hexs !== '0) $display("[TB] FAIL reset_hexs: got %h expected 0", hexs); else passed++;
    total++; if (frame_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", frame_valid); else passed++;
    total++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", frame_err); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (frame_cnt !== '0) $display("[TB] FAIL reset_cnt: got %0d expected 0", frame_cnt); else passed++;
    rstn = 1'b1;
    model_reset();
    tick(2);
  endtask

  task automatic test_single_frame();
    int v0, e0;
    logic [WIDTH-1:0] w;
    v0 = valid_seen; e0 = err_seen; last_lat = -1;
    w = 16'hA5C3;
    for (int i = WIDTH - 1; i >= 8; i--) send_bit(w[i] ? 1 : 0, 4);
    total++; if (busy !== 1'b1) $display("[TB] FAIL single_busy_mid: got %b expected 1", busy); else passed++;
    for (int i = 7; i >= 0; i--) send_bit(w[i] ? 1 : 0, 4);
    tick(6);
    total++; if (last_lat != 4) $display("[TB] FAIL single_latency: got %0d expected 4", last_lat); else passed++;
    total++; if (hexs !== 16'hA5C3) $display("[TB] FAIL single_hexs: got %h expected a5c3", hexs); else passed++;
    total++; if (frame_cnt !== CNT_W'(1)) $display("[TB] FAIL single_cnt: got %0d expected 1", frame_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL single_busy_end: got %b expected 0", busy); else passed++;
    total++; if (valid_seen - v0 != 1) $display("[TB] FAIL single_pulses: got %0d expected 1", valid_seen - v0); else passed++;
    total++; if (err_seen - e0 != 0) $display("[TB] FAIL single_err: got %0d expected 0", err_seen - e0); else passed++;
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    obs_frames.delete(); exp_frames.delete();
    send_word(16'h0001, 4);
    send_word(16'hFFFF, 4);
    tick(6);
    total++; if (valid_seen - v0 != 2) $display("[TB] FAIL b2b_pulses: got %0d expected 2", valid_seen - v0); else passed++;
    total++; if (err_seen - e0 != 0) $display("[TB] FAIL b2b_err: got %0d expected 0", err_seen - e0); else passed++;
    total++; if (hexs !== 16'hFFFF) $display("[TB] FAIL b2b_hexs: got %h expected ffff", hexs); else passed++;
    total++; if (frame_cnt !== CNT_W'(exp_cnt)) $display("[TB] FAIL b2b_cnt: got %0d expected %0d", frame_cnt, exp_cnt); else passed++;
    total++; if (obs_frames.size() != exp_frames.size()) $display("[TB] FAIL b2b_nframes: got %0d expected %0d", obs_frames.size(), exp_frames.size()); else passed++;
    while (obs_frames.size() > 0 && exp_frames.size() > 0) begin
      logic [WIDTH-1:0] o, e;
      o = obs_frames.pop_front(); e = exp_frames.pop_front();
      total++; if (o !== e) $display("[TB] FAIL b2b_frame: got %h expected %h", o, e); else passed++;
    end
  endtask

  task automatic test_timeout();
    int v0, e0;
    logic [WIDTH-1:0] prior;
    v0 = valid_seen; e0 = err_seen; prior = exp_hexs;
    for (int i = 0; i < 7; i++) send_bit(int'($urandom_range(0, 1)), 4);
    tick(TIMEOUT + 10);
    model_bits.delete();
    total++; if (err_seen - e0 != 1) $display("[TB] FAIL timeout_err: got %0d expected 1", err_seen - e0); else passed++;
    total++; if (valid_seen - v0 != 0) $display("[TB] FAIL timeout_valid: got %0d expected 0", valid_seen - v0); else passed++;
    total++; if (hexs !== prior) $display("[TB] FAIL timeout_hexs: got %h expected %h", hexs, prior); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL timeout_busy: got %b expected 0", busy); else passed++;
    send_word(16'h1234, 4);
    tick(6);
    total++; if (hexs !== 16'h1234) $display("[TB] FAIL timeout_next_hexs: got %h expected 1234", hexs); else passed++;
    total++; if (frame_cnt !== CNT_W'(exp_cnt)) $display("[TB] FAIL timeout_next_cnt: got %0d expected %0d", frame_cnt, exp_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) send_bit(int'($urandom_range(0, 1)), 4);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    model_reset();
    total++; if (hexs !== '0) $display("[TB] FAIL midrst_hexs: got %h expected 0", hexs); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else passed++;
    total++; if (frame_cnt !== '0) $display("[TB] FAIL midrst_cnt: got %0d expected 0", frame_cnt); else passed++;
    total++; if ({frame_valid, frame_err} !== 2'b00) $display("[TB] FAIL midrst_pulses: got %b expected 00", {frame_valid, frame_err}); else passed++;
    tick(2);
    send_word(16'hBEEF, 4);
    tick(6);
    total++; if (hexs !== 16'hBEEF) $display("[TB] FAIL midrst_next_hexs: got %h expected beef", hexs); else passed++;
    total++; if (frame_cnt !== CNT_W'(1)) $display("[TB] FAIL midrst_next_cnt: got %0d expected 1", frame_cnt); else passed++;
  endtask

  task automatic test_random();
    int e0;
    e0 = err_seen;
    obs_frames.delete(); exp_frames.delete();
    for (int f = 0; f < 24; f++) begin
      send_word(WIDTH'($urandom), int'($urandom_range(2, 5)));
      tick(6 + int'($urandom_range(0, 20)));
      total++; if (hexs !== exp_hexs) $display("[TB] FAIL random_hexs: got %h expected %h", hexs, exp_hexs); else passed++;
      total++; if (frame_cnt !== CNT_W'(exp_cnt)) $display("[TB] FAIL random_cnt: got %0d expected %0d", frame_cnt, exp_cnt); else passed++;
    end
    total++; if (err_seen - e0 != 0) $display("[TB] FAIL random_err: got %0d expected 0", err_seen - e0); else passed++;
    total++; if (obs_frames.size() != exp_frames.size()) $display("[TB] FAIL random_nframes: got %0d expected %0d", obs_frames.size(), exp_frames.size()); else passed++;
    while (obs_frames.size() > 0 && exp_frames.size() > 0) begin
      logic [WIDTH-1:0] o, e;
      o = obs_frames.pop_front(); e = exp_frames.pop_front();
      total++; if (o !== e) $display("[TB] FAIL random_frame: got %h expected %h", o, e); else passed++;
    end
  endtask

  task automatic test_wrap();
    int v0;
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    model_reset();
    tick(2);
    v0 = valid_seen;
    for (int f = 0; f < 256; f++) begin
      send_word(WIDTH'($urandom), 2);
      if (f == 254) begin
        tick(6);
        total++; if (frame_cnt !== CNT_W'(255)) $display("[TB] FAIL wrap_cnt_max: got %0d expected 255", frame_cnt); else passed++;
      end
    end
    tick(6);
    total++; if (frame_cnt !== '0) $display("[TB] FAIL wrap_cnt: got %0d expected 0", frame_cnt); else passed++;
    total++; if (valid_seen - v0 != 256) $display("[TB] FAIL wrap_pulses: got %0d expected 256", valid_seen - v0); else passed++;
    total++; if (hexs !== exp_hexs) $display("[TB] FAIL wrap_hexs: got %h expected %h", hexs, exp_hexs); else passed++;
  endtask

  task automatic test_clear();
    int v0;
    logic [WIDTH-1:0] exp_after;
    send_word(16'h5A5A, 4);
    tick(6);
    total++; if (hexs !== 16'h5A5A) $display("[TB] FAIL clear_pre_hexs: got %h expected 5a5a", hexs); else passed++;
    v0 = valid_seen;
`ifdef LED_RX_CLR_EN
    exp_after = '0;
`else
    exp_after = 16'h5A5A;
`endif
    ser_clr = 1'b0;
    tick(4);
    ser_clr = 1'b1;
    tick(6);
    total++; if (hexs !== exp_after) $display("[TB] FAIL clear_hexs: got %h expected %h", hexs, exp_after); else passed++;
    total++; if (valid_seen - v0 != 0) $display("[TB] FAIL clear_valid: got %0d expected 0", valid_seen - v0); else passed++;
    total++; if (frame_cnt !== CNT_W'(exp_cnt)) $display("[TB] FAIL clear_cnt: got %0d expected %0d", frame_cnt, exp_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL clear_busy: got %b expected 0", busy); else passed++;
  endtask

  initial begin
    $display("[TB] starting led_sync_rx bench");
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    test_wrap();
    test_clear();
    total++; if (both_seen != 0) $display("[TB] FAIL valid_and_err: got %0d expected 0", both_seen); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
